// File: rtl/tape_pkg.sv
// tape_pkg: shared constants, one-hot state indices and sizing helper for the tape word assembler
package tape_pkg;
  localparam int CHAR_W = 5;
  localparam int IDLE = 0;
  localparam int REQ = 1;
  localparam int REL = 2;
  localparam int DONE = 3;
  localparam int NSTATE = 4;
  function automatic int nchar(input int word_w, input int char_w);
    return word_w / char_w;
  endfunction
endpackage

// File: rtl/tape_char_fetch.sv
// tape_char_fetch: four-phase request/release engine toward the tape reader
module tape_char_fetch #(
  parameter int CHAR_W = tape_pkg::CHAR_W
) (
  input  logic              in_req,
  input  logic              in_rel,
  input  logic              input_val,
  input  logic [CHAR_W-1:0] input_data,
  output logic              input_rdy,
  output logic              char_stb,
  output logic [CHAR_W-1:0] char_data,
  output logic              released
);
  // char_stb lasts one cycle because a capture always moves REQ to REL
  assign input_rdy = in_req;
  assign char_stb  = in_req & input_val;
  assign char_data = input_data;
  assign released  = in_rel & ~input_val;
endmodule

// File: rtl/tape_word_assembler.sv
// tape_word_assembler: packs NCHAR tape characters, most significant first, into one CPU word
module tape_word_assembler #(
  parameter int CHAR_W = tape_pkg::CHAR_W,
  parameter int WORD_W = 30,
  parameter bit SKIP_BLANK = 1'b1,
  localparam int NCHAR = tape_pkg::nchar(WORD_W, CHAR_W),
  localparam int CNT_W = $clog2(NCHAR + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic              input_rdy,
  input  logic              input_val,
  input  logic [CHAR_W-1:0] input_data,
  output logic              word_val,
  input  logic              word_rdy,
  output logic [WORD_W-1:0] word_data,
  output logic              busy,
  output logic [CNT_W-1:0]  char_cnt
);
  import tape_pkg::*;
  if (WORD_W % CHAR_W != 0) begin : g_bad_width
    $error("WORD_W must be an integer multiple of CHAR_W");
  end
  logic [NSTATE-1:0] state, state_nx;
  logic              char_stb, released, full, keep;
  logic [CHAR_W-1:0] char_data;
  tape_char_fetch #(.CHAR_W(CHAR_W)) u_fetch (
    .in_req    (state[REQ]),
    .in_rel    (state[REL]),
    .input_val (input_val),
    .input_data(input_data),
    .input_rdy (input_rdy),
    .char_stb  (char_stb),
    .char_data (char_data),
    .released  (released)
  );
  assign full = char_cnt == CNT_W'(NCHAR);
  // blank characters still complete a handshake, they just never reach the word
  assign keep = !(SKIP_BLANK && char_data == '0);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= NSTATE'(1 << IDLE);
    else state <= state_nx;
  always_comb begin
    state_nx = '0;
    state_nx[IDLE] = (state[IDLE] & ~start) | (state[DONE] & word_rdy);
    state_nx[REQ]  = (state[IDLE] & start) | (state[REQ] & ~input_val) | (released & ~full);
    state_nx[REL]  = char_stb | (state[REL] & input_val);
    state_nx[DONE] = (released & full) | (state[DONE] & ~word_rdy);
  end
  always_comb begin
    busy     = ~state[IDLE];
    word_val = state[DONE];
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      word_data <= '0;
      char_cnt  <= '0;
    end else if (state[IDLE] && start) begin
      word_data <= '0;
      char_cnt  <= '0;
    end else if (char_stb && keep) begin
      word_data <= {word_data[WORD_W-CHAR_W-1:0], char_data};
      char_cnt  <= char_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_tape_word_assembler.sv
// tb_tape_word_assembler: scoreboard bench with a four-phase tape model, both blank-skip settings
module tb_tape_word_assembler;
  localparam int CHAR_W = 5;
  localparam int WORD_W = 30;
  logic clk = 1'b0, resetn = 1'b1, start = 1'b0, input_val = 1'b0, word_rdy = 1'b0, sel = 1'b0;
  logic [CHAR_W-1:0] input_data = '0;
  logic rdy_a, rdy_b, val_a, val_b, busy_a, busy_b;
  logic [WORD_W-1:0] wd_a, wd_b;
  logic [2:0] cnt_a, cnt_b;
  logic input_rdy, word_val, busy;
  logic [WORD_W-1:0] word_data;
  logic [2:0] char_cnt;
  int checks = 0, fails = 0, rises = 0, rise_base = 0, exp_rises = 0;
  logic [WORD_W-1:0] exp_q[$];
  logic [CHAR_W-1:0] tape_q[$];

  always #5 clk = ~clk;
  always @(posedge input_rdy) rises++;

  tape_word_assembler #(.CHAR_W(CHAR_W), .WORD_W(WORD_W), .SKIP_BLANK(1'b1)) dut_skip (
    .clk(clk), .resetn(resetn), .start(start & ~sel), .input_rdy(rdy_a), .input_val(input_val),
    .input_data(input_data), .word_val(val_a), .word_rdy(word_rdy), .word_data(wd_a),
    .busy(busy_a), .char_cnt(cnt_a));
  tape_word_assembler #(.CHAR_W(CHAR_W), .WORD_W(WORD_W), .SKIP_BLANK(1'b0)) dut_keep (
    .clk(clk), .resetn(resetn), .start(start & sel), .input_rdy(rdy_b), .input_val(input_val),
    .input_data(input_data), .word_val(val_b), .word_rdy(word_rdy), .word_data(wd_b),
    .busy(busy_b), .char_cnt(cnt_b));

  assign input_rdy = sel ? rdy_b : rdy_a;
  assign word_val  = sel ? val_b : val_a;
  assign busy      = sel ? busy_b : busy_a;
  assign word_data = sel ? wd_b : wd_a;
  assign char_cnt  = sel ? cnt_b : cnt_a;

  function automatic logic [WORD_W-1:0] model_word(input bit skip);
    logic [WORD_W-1:0] w = '0;
    foreach (tape_q[i]) if (!(skip && tape_q[i] == '0)) w = {w[WORD_W-CHAR_W-1:0], tape_q[i]};
    return w;
  endfunction

  task automatic start_word();
    exp_q.push_back(model_word(!sel));
    exp_rises = tape_q.size();
    rise_base = rises;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_char(input logic [CHAR_W-1:0] d, input int hold, output bit ok, output bit quiet,
                           output logic [2:0] c0, output logic [2:0] c1);
    int n = 0;
    ok = 1'b1;
    quiet = 1'b1;
    while (input_rdy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    c0 = char_cnt;
    c1 = char_cnt;
    if (input_rdy !== 1'b1) begin ok = 1'b0; return; end
    input_val = 1'b1;
    input_data = d;
    n = 0;
    do begin @(negedge clk); n++; end while (input_rdy === 1'b1 && n < 100);
    if (input_rdy === 1'b1) ok = 1'b0;
    c1 = char_cnt;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (input_rdy !== 1'b0 || char_cnt !== c1) quiet = 1'b0;
    end
    input_val = 1'b0;
    input_data = CHAR_W'($urandom);
  endtask

  task automatic feed(input int hold);
    bit ok, quiet;
    logic [2:0] c0, c1;
    logic [CHAR_W-1:0] d;
    while (tape_q.size() > 0) begin
      d = tape_q.pop_front();
      send_char(d, hold, ok, quiet, c0, c1);
      if (!ok) begin
        checks++; fails++;
        $display("FAIL handshake: input_rdy stuck for char %h", d);
        tape_q.delete();
        return;
      end
      if (hold > 0) begin
        checks++;
        if (!quiet || c1 !== c0 + 3'd1) begin
          fails++;
          $display("FAIL slow_tape: char_cnt %0d->%0d quiet=%0b, required %0d->%0d quiet=1", c0, c1, quiet, c0, c0 + 3'd1);
        end
      end
    end
  endtask

  task automatic collect(input int stall);
    int n = 0;
    logic [WORD_W-1:0] exp, held;
    while (word_val !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    exp = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
    checks++;
    if (word_val !== 1'b1) begin
      fails++;
      $display("FAIL word_val_timeout: word_val=%b required 1", word_val);
      return;
    end
    checks++;
    if (word_data !== exp) begin fails++; $display("FAIL word_data: got %h required %h", word_data, exp); end
    checks++;
    if (rises - rise_base != exp_rises) begin
      fails++; $display("FAIL rdy_rises: got %0d required %0d", rises - rise_base, exp_rises);
    end
    held = word_data;
    for (int i = 0; i < stall; i++) begin
      start = (i == 10);
      @(negedge clk);
      checks++;
      if (word_val !== 1'b1 || word_data !== held || input_rdy !== 1'b0) begin
        fails++;
        $display("FAIL backpressure: val=%b data=%h rdy=%b required 1 %h 0", word_val, word_data, input_rdy, held);
      end
    end
    start = 1'b0;
    word_rdy = 1'b1;
    @(negedge clk);
    word_rdy = 1'b0;
    checks++;
    if (word_val !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL accept: word_val=%b busy=%b required 0 0", word_val, busy);
    end
  endtask

  task automatic test_reset();
    #1 resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({input_rdy, word_val, busy} !== 3'b000) begin
      fails++; $display("FAIL reset_ctrl: rdy/val/busy=%b required 000", {input_rdy, word_val, busy});
    end
    checks++;
    if (word_data !== '0 || char_cnt !== '0) begin
      fails++; $display("FAIL reset_data: data=%h cnt=%0d required 0 0", word_data, char_cnt);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_word();
    sel = 1'b1;
    for (int i = 1; i <= 6; i++) tape_q.push_back(CHAR_W'(i));
    start_word();
    checks++;
    if (input_rdy !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL start_latency: rdy=%b busy=%b required 1 1", input_rdy, busy);
    end
    feed(0);
    collect(0);
  endtask

  task automatic test_blank_skip();
    sel = 1'b0;
    tape_q.push_back('0);
    repeat (6) tape_q.push_back(5'h1f);
    start_word();
    feed(0);
    collect(0);
    sel = 1'b1;
    tape_q.push_back('0);
    repeat (5) tape_q.push_back(5'h1f);
    start_word();
    feed(0);
    collect(0);
    sel = 1'b0;
  endtask

  task automatic test_backpressure();
    repeat (6) tape_q.push_back(CHAR_W'($urandom_range(1, 31)));
    start_word();
    feed(0);
    collect(20);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || input_rdy !== 1'b0) begin
      fails++; $display("FAIL stray_start: busy=%b rdy=%b required 0 0", busy, input_rdy);
    end
  endtask

  task automatic test_slow_tape();
    for (int i = 0; i < 6; i++) tape_q.push_back(CHAR_W'(3 + 4 * i));
    start_word();
    feed(5);
    collect(0);
  endtask

  task automatic test_async_reset();
    int n = 0;
    for (int i = 0; i < 3; i++) tape_q.push_back(CHAR_W'(9 + i));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    feed(0);
    while (input_rdy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (input_rdy !== 1'b0 || busy !== 1'b0 || char_cnt !== 3'd0 || word_val !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: rdy=%b busy=%b cnt=%0d val=%b required 0 0 0 0", input_rdy, busy, char_cnt, word_val);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) tape_q.push_back(CHAR_W'(20 + i));
    start_word();
    feed(0);
    collect(0);
  endtask

  task automatic test_back_to_back();
    repeat (6) tape_q.push_back(CHAR_W'($urandom_range(1, 31)));
    start_word();
    feed(0);
    collect(0);
    repeat (6) tape_q.push_back(CHAR_W'($urandom_range(0, 31)));
    start_word();
    checks++;
    if (busy !== 1'b1) begin fails++; $display("FAIL back_to_back_busy: busy=%b required 1", busy); end
    feed(0);
    collect(0);
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_blank_skip();
    test_backpressure();
    test_slow_tape();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
